uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
- REQ-001 Parameter WORDS_MAX, default 4096: maximum image length in 32-bit words.
- REQ-002 Parameter TIMEOUT, default 4000000: idle cycles allowed between bytes inside a frame.
- REQ-003 clk  input  1  single clock for all logic.
- REQ-004 reset  input  1  synchronous, active-high reset; one clock, no other clock domains.
- REQ-005 rx_valid  input  1  UART receiver holds a byte.
- REQ-006 rx_data  input  8  received byte, valid while rx_valid=1.
- REQ-007 rx_rd  output  1  one-cycle pulse that consumes the byte.
- REQ-008 mem_addr  output  16  byte address of the write; RAM uses bits [13:2].
- REQ-009 mem_d  output  32  write data.
- REQ-010 mem_wr  output  1  one-cycle write strobe.
- REQ-011 cpu_hold  output  1  holds the CPU in reset while high.
- REQ-012 done  output  1  image loaded and checksum matched.
- REQ-013 error  output  1  last frame failed.

Function
- REQ-014 Frame format: sync 0xA5, LEN_LO, LEN_HI (word count N, 16 bit), 4*N data bytes little-endian per word (first byte -> bits [7:0]), CSUM byte.
- REQ-015 FSM states: SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- REQ-016 SYNC: a byte of 0xA5 goes to LEN0; any other byte is consumed and discarded.
- REQ-017 LEN1 with N=0 goes to CSUM.
- REQ-018 LEN1 with N>WORDS_MAX goes to ERR.
- REQ-019 Otherwise LEN1 goes to DATA.
- REQ-020 Byte accept: in every state except DONE, rx_rd=1 for exactly one cycle when rx_valid=1 and rx_rd was 0 the previous cycle; rx_data is sampled in that same cycle.
- REQ-021 The cycle after a pulse shall not accept, which covers receiver valid-drop latency.
- REQ-022 DATA: bytes shift into a 32-bit assembly register.
- REQ-023 In the cycle after the 4th byte of a word is accepted, mem_wr=1 for one cycle, mem_d=assembled word and mem_addr=word_index*4 (word_index from 0).
- REQ-024 word_index increments after each write.
- REQ-025 After word N-1 is written, the FSM enters CSUM.
- REQ-026 Checksum: 8-bit modular sum of all data bytes only, wrapping mod 256; it is cleared on entering LEN0.
- REQ-027 CSUM: received byte equal to the sum goes to DONE; otherwise goes to ERR.
- REQ-028 DONE: cpu_hold=0, done=1, rx_rd held 0 so the CPU owns the UART; DONE is left only by reset.
- REQ-029 ERR: error=1, cpu_hold=1; bytes are consumed.
- REQ-030 A 0xA5 in ERR clears error and goes to LEN0; other bytes are discarded.
- REQ-031 Timeout: in LEN0, LEN1, DATA and CSUM, a counter increments each cycle without an accepted byte.
- REQ-032 The timeout counter clears on each accept.
- REQ-033 When the timeout counter reaches TIMEOUT, the FSM goes to ERR.
- REQ-034 SYNC and DONE have no timeout.
- REQ-035 mem_wr shall never assert outside DATA.
- REQ-036 Writes shall only target word_index < N.
- REQ-037 A partial word is never written.
- REQ-038 Re-sync from ERR overwrites memory from word 0; earlier contents beyond the new N are untouched.

Reset
- REQ-039 Reset (reset=1 sampled at a clk edge) sets state SYNC, cpu_hold=1, done=0, error=0, rx_rd=0, mem_wr=0, mem_addr=0, mem_d=0, and clears word_index, checksum and the timeout counter.
- REQ-040 Reset mid-frame aborts the frame with no further writes; the next frame must start with sync.

Verification
- REQ-041 Bytes A5 02 00 11 22 33 44 55 66 77 88 64 -> two writes (addr 0x0000 data 0x44332211, addr 0x0004 data 0x88776655); then done=1, cpu_hold=0, error=0.
- REQ-042 Bytes 00 FF A5 00 00 00 -> no mem_wr; 00 and FF discarded; done=1.
- REQ-043 Bytes A5 01 00 01 02 03 04 00 (correct CSUM 0x0A) -> one write of 0x04030201; then error=1, cpu_hold=1; a following A5 01 00 01 02 03 04 0A -> done=1.
- REQ-044 Bytes A5 01 10 (N=4097) -> ERR with no writes.
- REQ-045 A5 01 00 then 2 data bytes, then silence for TIMEOUT cycles (TIMEOUT=100 in bench) -> error=1 with no mem_wr.
- REQ-046 rx_valid held high continuously -> rx_rd pulses at most every other cycle.
- REQ-047 Reset asserted after 3 bytes of data -> no write, state SYNC, cpu_hold=1.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: receives a framed, checksummed memory image over a UART byte stream and writes it into RAM while holding the CPU in reset.
module uart_loader #(
  parameter int WORDS_MAX = 4096,
  parameter int TIMEOUT = 4000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_d,
  output logic        mem_wr,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  state_t state, nxt;
  logic rd_q, timed, to;
  logic [15:0] n, idx, len;
  logic [1:0] bcnt;
  logic [7:0] csum;
  logic [31:0] asm_w;
  logic [TW-1:0] tcnt;
  // rd_q blocks the cycle after a pulse so a receiver's valid-drop latency never double-reads
  assign rx_rd = rx_valid && !rd_q && state != DONE;
  assign timed = state inside {LEN0, LEN1, DATA, CSUM};
  assign to = timed && tcnt >= TW'(TIMEOUT);
  assign len = {rx_data, n[7:0]};
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign error = state == ERR;
  always_ff @(posedge clk)
    if (reset) state <= SYNC;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (to) nxt = ERR;
    else
      case (state)
        SYNC, ERR: nxt = rx_rd && rx_data == 8'hA5 ? LEN0 : state;
        LEN0: nxt = rx_rd ? LEN1 : LEN0;
        LEN1: nxt = !rx_rd ? LEN1 : len == 16'd0 ? CSUM : len > 16'(WORDS_MAX) ? ERR : DATA;
        DATA: nxt = mem_wr && idx == n - 16'd1 ? CSUM : DATA;
        CSUM: nxt = !rx_rd ? CSUM : rx_data == csum ? DONE : ERR;
        default: nxt = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0;
      n <= '0;
      idx <= '0;
      bcnt <= '0;
      csum <= '0;
      asm_w <= '0;
      tcnt <= '0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_d <= '0;
    end else begin
      rd_q <= rx_rd;
      mem_wr <= 1'b0;
      tcnt <= rx_rd || !timed ? '0 : tcnt + TW'(1);
      if (nxt == LEN0 && state != LEN0) begin
        csum <= '0;
        idx <= '0;
        bcnt <= '0;
      end
      if (state == LEN0 && rx_rd) n[7:0] <= rx_data;
      if (state == LEN1 && rx_rd) n[15:8] <= rx_data;
      if (state == DATA && rx_rd && !to) begin
        asm_w <= {rx_data, asm_w[31:8]};
        bcnt <= bcnt + 2'd1;
        csum <= csum + rx_data;
        if (bcnt == 2'd3) begin
          mem_wr <= 1'b1;
          mem_d <= {rx_data, asm_w[31:8]};
          mem_addr <= {idx[13:0], 2'b00};
        end
      end
      if (mem_wr) idx <= idx + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized frames checked against a frame-level model of expected writes and outcome.
module tb_uart_loader;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_rd, mem_wr, cpu_hold, done, error;
  logic [15:0] mem_addr;
  logic [31:0] mem_d;
  int checks = 0, failures = 0;
  int pulses = 0, b2b = 0;
  logic prev_rd = 1'b0;
  logic [47:0] wq[$];
  always #5 clk = ~clk;
  uart_loader #(.WORDS_MAX(4096), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_wr(mem_wr), .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always @(negedge clk) begin
    if (mem_wr) wq.push_back({mem_addr, mem_d});
    if (rx_rd) pulses++;
    if (rx_rd && prev_rd) b2b++;
    prev_rd = rx_rd;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data = b;
    rx_valid = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (rx_rd) break;
      k++;
    end
    chk("rx_rd_wait", rx_rd, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tick($urandom_range(0, 2));
  endtask
  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask
  task automatic make_frame(input logic [31:0] w[$], input bit bad, output logic [7:0] q[$]);
    logic [15:0] nw;
    logic [7:0] s;
    nw = 16'(w.size());
    s = 8'h00;
    q = {};
    q.push_back(8'hA5);
    q.push_back(nw[7:0]);
    q.push_back(nw[15:8]);
    foreach (w[i])
      for (int j = 0; j < 4; j++) begin
        q.push_back(w[i][8*j +: 8]);
        s = s + w[i][8*j +: 8];
      end
    q.push_back(bad ? s ^ 8'h01 : s);
  endtask
  task automatic check_writes(input string tag, input int base, input logic [31:0] w[$]);
    chk({tag, "_nwr"}, wq.size() - base, w.size());
    if (wq.size() - base == w.size())
      foreach (w[i]) begin
        chk({tag, "_addr"}, wq[base + i][47:32], 16'(i * 4));
        chk({tag, "_data"}, wq[base + i][31:0], w[i]);
      end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] bq[$];
    logic [31:0] ww[$];
    int base, p, b;
    bit bad;
    do_reset();
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rx_rd", rx_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_d", mem_d, 0);
    // two-word image
    base = wq.size();
    bq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_q(bq);
    tick(3);
    ww = '{32'h44332211, 32'h88776655};
    check_writes("two_word", base, ww);
    chk("two_word_done", done, 1);
    chk("two_word_hold", cpu_hold, 0);
    chk("two_word_err", error, 0);
    p = pulses;
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    tick(6);
    rx_valid = 1'b0;
    chk("done_no_rd", pulses - p, 0);
    chk("done_stays", done, 1);
    // garbage before sync, empty image
    do_reset();
    base = wq.size();
    bq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q(bq);
    tick(3);
    ww = {};
    check_writes("empty", base, ww);
    chk("empty_done", done, 1);
    // bad checksum then re-sync
    do_reset();
    base = wq.size();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_q(bq);
    tick(3);
    ww = '{32'h04030201};
    check_writes("badsum", base, ww);
    chk("badsum_err", error, 1);
    chk("badsum_hold", cpu_hold, 1);
    chk("badsum_done", done, 0);
    base = wq.size();
    bq[7] = 8'h0A;
    send_q(bq);
    tick(3);
    check_writes("resync", base, ww);
    chk("resync_done", done, 1);
    chk("resync_err", error, 0);
    // oversize length
    do_reset();
    base = wq.size();
    bq = '{8'hA5, 8'h01, 8'h10};
    send_q(bq);
    tick(3);
    ww = {};
    check_writes("oversize", base, ww);
    chk("oversize_err", error, 1);
    // inter-byte timeout
    do_reset();
    base = wq.size();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_q(bq);
    tick(50);
    chk("tmo_early", error, 0);
    tick(60);
    chk("tmo_err", error, 1);
    check_writes("tmo", base, ww);
    // continuous valid
    do_reset();
    p = pulses;
    b = b2b;
    rx_data = 8'h00;
    rx_valid = 1'b1;
    tick(20);
    rx_valid = 1'b0;
    tick(1);
    chk("cont_b2b", b2b - b, 0);
    chk("cont_pulses", pulses - p, 10);
    // reset mid-frame
    do_reset();
    base = wq.size();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_q(bq);
    do_reset();
    tick(3);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_done", done, 0);
    chk("midrst_err", error, 0);
    bq = '{8'h04, 8'h0A};
    send_q(bq);
    tick(3);
    check_writes("midrst", base, ww);
    chk("midrst_tail_done", done, 0);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_q(bq);
    tick(3);
    ww = '{32'h04030201};
    check_writes("midrst_new", base, ww);
    chk("midrst_new_done", done, 1);
    // randomized frames
    for (int it = 0; it < 8; it++) begin
      do_reset();
      base = wq.size();
      ww = {};
      repeat ($urandom_range(1, 6)) ww.push_back($urandom);
      bad = $urandom_range(0, 2) == 0;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        send_byte(g == 8'hA5 ? 8'h00 : g);
      end
      make_frame(ww, bad, bq);
      send_q(bq);
      tick(3);
      check_writes("rand", base, ww);
      chk("rand_done", done, !bad);
      chk("rand_err", error, bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
